// File: rtl/usf_adc_pkg.sv
// Shared types and ADC configuration helpers for the dual-channel LTC2308 capture front end.
package usf_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_GAP
  } state_t;

  // Single-ended, unipolar, no sleep; S1/S0 fixed at 0 so only channels 0 and 1 are reachable.
  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  function automatic logic [5:0] cfg_word(input logic ch);
    return {CFG_SD, ch, 1'b0, 1'b0, CFG_UNI, CFG_SLP};
  endfunction

endpackage

// File: rtl/usf_adc_spi_frame.sv
// One 12-bit SPI shift window: clocks out the 6-bit config on din while capturing
// 12 result bits from dout on the sck rising edges.
module usf_adc_spi_frame
  import usf_adc_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cfg,
  input  logic        dout,
  output logic        sck,
  output logic        din,
  output logic [11:0] data,
  output logic        done
);

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [3:0]    bit_cnt;
  logic [11:0]   rx;
  logic [4:0]    tx;
  logic          half_end;

  assign half_end = (half_cnt == HW'(SCK_HALF - 1));

  // The first config bit is put on din at start so it is stable before the first rising edge;
  // later bits change on falling edges. done rises together with the last falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      sck      <= 1'b0;
      din      <= 1'b0;
      data     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        half_cnt <= '0;
        bit_cnt  <= '0;
        sck      <= 1'b0;
        din      <= cfg[5];
        tx       <= cfg[4:0];
      end else if (active) begin
        if (!half_end) begin
          half_cnt <= half_cnt + 1'b1;
        end else begin
          half_cnt <= '0;
          if (!sck) begin
            sck <= 1'b1;
            rx  <= {rx[10:0], dout};
          end else begin
            sck <= 1'b0;
            if (bit_cnt == 4'd11) begin
              active <= 1'b0;
              done   <= 1'b1;
              data   <= rx;
              din    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              din     <= tx[4];
              tx      <= {tx[3:0], 1'b0};
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/usf_adc_top.sv
// Alternating A/B capture sequencer for an LTC2308-style ADC; packs each A/B pair
// into one 32-bit word and strobes it into the downstream sample FIFO.
module usf_adc_top
  import usf_adc_pkg::*;
#(
  parameter int   SCK_HALF    = 2,
  parameter int   CONV_CYCLES = 80,
  parameter int   GAP_CYCLES  = 4,
  parameter logic CH_A        = 1'b0,
  parameter logic CH_B        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        sck,
  output logic        cs,
  output logic        din,
  input  logic        dout,
  output logic [31:0] fifo_in_writedata,
  output logic        fifo_in_write
);

  localparam int CW = $clog2(CONV_CYCLES) + 1;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          start;
  logic          done;
  logic [11:0]   spi_data;
  logic [11:0]   reading_a;
  logic [11:0]   reading_b;
  logic          next_ch;
  logic          label_ch;
  logic          primed;

  assign cs = (state == ST_CONV);

  usf_adc_spi_frame #(
    .SCK_HALF(SCK_HALF)
  ) u_frame (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .cfg  (cfg_word(next_ch)),
    .dout (dout),
    .sck  (sck),
    .din  (din),
    .data (spi_data),
    .done (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      // The done cycle already has cs and sck low, so it counts as the first gap cycle.
      if (next_state != state)
        cnt <= (next_state == ST_GAP) ? CW'(1) : '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    unique case (state)
      ST_IDLE:  if (en) next_state = ST_CONV;
      ST_CONV: begin
        if (cnt == CW'(CONV_CYCLES - 1)) begin
          start      = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: if (done) next_state = ST_GAP;
      ST_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1))
          next_state = en ? ST_CONV : ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Data arriving in a frame belongs to the channel configured one frame earlier (label_ch);
  // the first frame after IDLE only primes the ADC and its data is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reading_a         <= '0;
      reading_b         <= '0;
      next_ch           <= CH_A;
      label_ch          <= CH_A;
      primed            <= 1'b0;
      fifo_in_writedata <= '0;
      fifo_in_write     <= 1'b0;
    end else begin
      fifo_in_write <= 1'b0;
      if (state == ST_IDLE) begin
        primed  <= 1'b0;
        next_ch <= CH_A;
      end else if (done) begin
        if (primed) begin
          if (label_ch == CH_A) begin
            reading_a <= spi_data;
          end else begin
            reading_b         <= spi_data;
            fifo_in_writedata <= {4'h0, spi_data, 4'h0, reading_a};
            fifo_in_write     <= 1'b1;
          end
        end
        primed   <= 1'b1;
        label_ch <= next_ch;
        next_ch  <= (next_ch == CH_A) ? CH_B : CH_A;
      end
    end
  end

endmodule

// File: tb/tb_usf_adc_top.sv
// Directed bench for usf_adc_top with a behavioural LTC2308 model driving dout.
module tb_usf_adc_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        dout;
  logic        sck;
  logic        cs;
  logic        din;
  logic [31:0] fifo_in_writedata;
  logic        fifo_in_write;

  int errors = 0;
  int checks = 0;

  usf_adc_top dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .sck              (sck),
    .cs               (cs),
    .din              (din),
    .dout             (dout),
    .fifo_in_writedata(fifo_in_writedata),
    .fifo_in_write    (fifo_in_write)
  );

  always #10 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle++;

  // ADC model: config latched on sck rises, used at the next CONVST, result shifted out in the
  // following frame MSB first, advancing on sck falls.
  int          mode = 0;
  logic [11:0] val_a = '0;
  logic [11:0] val_b = '0;
  logic [5:0]  rx_cfg = '0;
  int          rx_n = 0;
  logic        conv_ch = 1'b0;
  logic [11:0] tx = '0;
  logic [5:0]  cfg_q[$];

  assign dout = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : tx[11];

  always @(posedge cs) conv_ch = rx_cfg[4];
  always @(negedge cs) begin
    tx   = conv_ch ? val_b : val_a;
    rx_n = 0;
  end
  always @(posedge sck) begin
    if (rx_n < 6) begin
      rx_cfg = {rx_cfg[4:0], din};
      rx_n++;
      if (rx_n == 6) cfg_q.push_back(rx_cfg);
    end
  end
  always @(negedge sck) tx = {tx[10:0], 1'b0};

  int   cs_rises = 0;
  int   cs_len = 0;
  int   last_cs_len = 0;
  logic cs_d = 1'b0;
  always @(negedge clk) begin
    if (cs) begin
      if (!cs_d) cs_rises++;
      cs_len++;
    end else if (cs_d) begin
      last_cs_len = cs_len;
      cs_len = 0;
    end
    cs_d = cs;
  end

  typedef struct {
    int          mode;
    logic [11:0] a;
    logic [11:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic [11:0] a, input logic [11:0] b);
    reset = 1'b0;
    en    = 1'b0;
    mode  = m;
    val_a = a;
    val_b = b;
    repeat (3) @(negedge clk);
    cfg_q.delete();
    reset = 1'b1;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic waitWrite(input int maxc, output bit ok, output logic [31:0] w,
                           output int unsigned t);
    ok = 1'b0;
    w  = '0;
    t  = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (fifo_in_write) begin
        ok = 1'b1;
        w  = fifo_in_writedata;
        t  = cycle;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] w1, w2;
    int unsigned t1, t2;
    int          r0;
    int          busy;

    vecs[0] = '{2, 12'hA5C, 12'h3C1, 32'h03C1_0A5C};
    vecs[1] = '{1, 12'h000, 12'h000, 32'h0FFF_0FFF};
    vecs[2] = '{0, 12'hFFF, 12'hFFF, 32'h0000_0000};
    vecs[3] = '{2, 12'hFFF, 12'h000, 32'h0000_0FFF};
    vecs[4] = '{2, 12'h001, 12'h800, 32'h0800_0001};

    reset = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_pins", {28'h0, cs, sck, din, fifo_in_write}, 32'h0);
    checkOutput("reset_wdata", fifo_in_writedata, 32'h0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].a, vecs[v].b);
      r0 = cs_rises;
      waitWrite(900, ok, w1, t1);
      checkOutput($sformatf("v%0d_write_seen", v), {31'h0, ok}, 32'h1);
      checkOutput($sformatf("v%0d_word", v), w1, vecs[v].exp);
      checkOutput($sformatf("v%0d_frames", v), cs_rises - r0, 32'd3);
      if (v == 0) begin
        checkOutput("cs_high_len", last_cs_len, 32'd80);
        checkOutput("cfg_count", cfg_q.size(), 32'd3);
        if (cfg_q.size() >= 3) begin
          checkOutput("cfg0", {26'h0, cfg_q[0]}, 32'b100010);
          checkOutput("cfg1", {26'h0, cfg_q[1]}, 32'b110010);
          checkOutput("cfg2", {26'h0, cfg_q[2]}, 32'b100010);
        end
      end
      @(negedge clk);
      checkOutput($sformatf("v%0d_strobe_width", v), {31'h0, fifo_in_write}, 32'h0);
      waitWrite(400, ok, w2, t2);
      checkOutput($sformatf("v%0d_period", v), t2 - t1, 32'd264);
      checkOutput($sformatf("v%0d_word2", v), w2, vecs[v].exp);
    end

    // en dropped during the shift window of the second B-labelled frame
    applyStimulus(2, 12'h123, 12'h456);
    r0 = cs_rises;
    waitWrite(900, ok, w1, t1);
    checkOutput("drop_first_write", w1, 32'h0456_0123);
    for (int i = 0; i < 400 && cs_rises < r0 + 5; i++) @(negedge clk);
    for (int i = 0; i < 200 && cs; i++) @(negedge clk);
    checkOutput("drop_in_shift", {30'h0, cs_rises == r0 + 5, cs}, 32'b10);
    repeat (20) @(negedge clk);
    en = 1'b0;
    waitWrite(60, ok, w1, t1);
    checkOutput("drop_write_seen", {31'h0, ok}, 32'h1);
    checkOutput("drop_word", w1, 32'h0456_0123);
    busy = 0;
    repeat (400) begin
      @(negedge clk);
      if (cs || sck || fifo_in_write) busy++;
    end
    checkOutput("drop_idle", busy, 32'd0);
    checkOutput("drop_hold", fifo_in_writedata, 32'h0456_0123);

    val_a = 12'h007;
    val_b = 12'h008;
    r0 = cs_rises;
    en = 1'b1;
    waitWrite(900, ok, w1, t1);
    checkOutput("reen_word", w1, 32'h0008_0007);
    checkOutput("reen_frames", cs_rises - r0, 32'd3);

    // reset asserted in the middle of a conversion
    for (int i = 0; i < 300 && !cs; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_pins", {28'h0, cs, sck, din, fifo_in_write}, 32'h0);
    checkOutput("midreset_wdata", fifo_in_writedata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    r0 = cs_rises;
    waitWrite(900, ok, w1, t1);
    checkOutput("restart_word", w1, 32'h0008_0007);
    checkOutput("restart_frames", cs_rises - r0, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
